// File: rtl/adder_arbiter.sv
// Two-port round-robin front end for the shared 8-bit adder (9-bit result).
// Latches the winning operands, runs one addition, and pulses gnt/done per port.
module adder_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       cin0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic       cin1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [8:0] sum,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic       op_cin_q, op_cin_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       busy_q, busy_d;
    logic [8:0] sum_q, sum_d;
    logic       win;
    logic [8:0] add_out;

    function automatic logic [8:0] add9(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin);
        add9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    endfunction

    // The single shared adder sees only the latched operands.
    assign add_out = add9(op_a_q, op_b_q, op_cin_q);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_cin_d = op_cin_q;
        sum_d    = sum_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        busy_d   = 1'b0;
        win      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port not served last wins.
                    win      = (req0 && req1) ? ~last_q : req1;
                    op_a_d   = win ? a1 : a0;
                    op_b_d   = win ? b1 : b0;
                    op_cin_d = win ? cin1 : cin0;
                    owner_d  = win;
                    last_d   = win;
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    busy_d   = 1'b1;
                    state_d  = ADD;
                end
            end
            ADD: begin
                sum_d   = add_out;
                done0_d = ~owner_q;
                done1_d = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            op_a_q   <= 8'd0;
            op_b_q   <= 8'd0;
            op_cin_q <= 1'b0;
            sum_q    <= 9'd0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_cin_q <= op_cin_d;
            sum_q    <= sum_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign sum   = sum_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a schedule-based model.
module tb_adder_arbiter;

    localparam int NC = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
    logic       cin0 = 1'b0, cin1 = 1'b0;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [8:0] sum;

    int n_checks = 0;
    int n_err    = 0;

    adder_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .a0   (a0),
        .b0   (b0),
        .cin0 (cin0),
        .req1 (req1),
        .a1   (a1),
        .b1   (b1),
        .cin1 (cin1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .done0(done0),
        .done1(done1),
        .sum  (sum),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs per cycle; cycle c is the interval after posedge number c.
    int   exp_g [0:NC];
    int   exp_d [0:NC];
    bit   exp_b [0:NC];
    int   exp_s [0:NC];
    int   edge_cnt = 0;

    // Model: the arbiter is free at a given edge unless an addition accepted at the
    // previous edge is still finishing; a grant schedules gnt+busy next cycle and
    // done plus the new sum the cycle after.
    initial begin
        int n, w, m_last, m_free, pend_cyc, pend_val;
        bit pend_ok;
        for (int i = 0; i <= NC; i++) begin
            exp_g[i] = -1; exp_d[i] = -1; exp_b[i] = 1'b0; exp_s[i] = 0;
        end
        m_last = 1; m_free = 0; pend_ok = 1'b0; pend_cyc = 0; pend_val = 0;
        forever begin
            @(posedge clk);
            n = edge_cnt;
            if (n + 2 < NC) begin
                if (rst) begin
                    exp_g[n+1] = -1; exp_d[n+1] = -1; exp_b[n+1] = 1'b0; exp_s[n+1] = 0;
                    m_last = 1; m_free = n + 1; pend_ok = 1'b0;
                end else begin
                    exp_s[n+1] = (pend_ok && pend_cyc == n + 1) ? pend_val : exp_s[n];
                    if (n >= m_free && (req0 || req1)) begin
                        w = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
                        exp_g[n+1] = w;
                        exp_b[n+1] = 1'b1;
                        exp_d[n+2] = w;
                        pend_ok  = 1'b1;
                        pend_cyc = n + 2;
                        pend_val = (w == 1) ? (int'(a1) + int'(b1) + int'(cin1))
                                            : (int'(a0) + int'(b0) + int'(cin0));
                        m_last = w;
                        m_free = n + 2;
                    end
                end
            end
            edge_cnt = n + 1;
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        int c;
        forever begin
            @(negedge clk);
            c = edge_cnt;
            if (c >= 1 && c < NC) begin
                check("m_gnt0",  gnt0,  (exp_g[c] == 0));
                check("m_gnt1",  gnt1,  (exp_g[c] == 1));
                check("m_done0", done0, (exp_d[c] == 0));
                check("m_done1", done1, (exp_d[c] == 1));
                check("m_busy",  busy,  exp_b[c]);
                check("m_sum",   sum,   exp_s[c][8:0]);
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int seq[$];
        apply_reset();
        check("rst_sum", sum, 9'h000);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {gnt0, gnt1, done0, done1}, 4'b0000);

        // Single request on port 0.
        req0 = 1'b1; a0 = 8'h0F; b0 = 8'h01; cin0 = 1'b0;
        @(negedge clk);
        check("single_gnt0", gnt0, 1'b1);
        check("single_busy", busy, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        check("single_done0", done0, 1'b1);
        check("single_sum", sum, 9'h010);
        check("single_busy_lo", busy, 1'b0);
        check("single_p1_quiet", {gnt1, done1}, 2'b00);

        // Maximum operands on port 1, then all zeros.
        req1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF; cin1 = 1'b1;
        @(negedge clk);
        check("max_gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        @(negedge clk);
        check("max_done1", done1, 1'b1);
        check("max_sum", sum, 9'h1FF);
        req1 = 1'b1; a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        check("zero_sum", sum, 9'h000);

        // Simultaneous first request after reset.
        apply_reset();
        req0 = 1'b1; a0 = 8'h10; b0 = 8'h20; cin0 = 1'b0;
        req1 = 1'b1; a1 = 8'h01; b1 = 8'h02; cin1 = 1'b0;
        @(negedge clk);
        check("tie_gnt0_first", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0;
        @(negedge clk);
        check("tie_done0", done0, 1'b1);
        check("tie_sum0", sum, 9'h030);
        @(negedge clk);
        check("tie_gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        @(negedge clk);
        check("tie_done1", done1, 1'b1);
        check("tie_sum1", sum, 9'h003);

        // Fairness: both ports request continuously.
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (gnt0) seq.push_back(0);
            if (gnt1) seq.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("fair_count", 9'(seq.size()), 9'd8);
        for (int i = 0; i < seq.size(); i++) check("fair_order", 9'(seq[i]), 9'(i % 2));

        // Operand isolation: operands change while the addition is in flight.
        req0 = 1'b1; a0 = 8'h03; b0 = 8'h04; cin0 = 1'b1;
        @(negedge clk);
        check("iso_gnt0", gnt0, 1'b1);
        req0 = 1'b0; a0 = 8'hAA; b0 = 8'hAA;
        @(negedge clk);
        check("iso_sum", sum, 9'h008);

        // Reset while the addition is in flight.
        req0 = 1'b1; a0 = 8'h55; b0 = 8'h11; cin0 = 1'b0;
        @(negedge clk);
        check("rmid_gnt0", gnt0, 1'b1);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        check("rmid_no_done", {done0, done1}, 2'b00);
        check("rmid_sum", sum, 9'h000);
        check("rmid_busy", busy, 1'b0);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        check("rmid_tie_gnt0", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            if (req0 && gnt0) begin
                req0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom);
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
            end
            if (req1 && gnt1) begin
                req1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
            end
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
